// File: rtl/out_port_sched.sv
// out_port_sched: packet-level round-robin scheduler for one output port of the multi-port cache
module out_port_sched #(
    parameter int IN_PORT_NUM = 16,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_en,
    input  logic [IN_PORT_NUM-1:0]         i_req,
    input  logic                           i_rd_vld,
    input  logic                           i_rd_eop,
    output logic [$clog2(IN_PORT_NUM)-1:0] o_sel,
    output logic                           o_sel_vld,
    output logic [IN_PORT_NUM-1:0]         o_rd_req,
    output logic                           o_busy,
    output logic                           o_pkt_done,
    output logic                           o_timeout,
    output logic [CNT_W-1:0]               o_pkt_cnt
);
    localparam int SW = $clog2(IN_PORT_NUM);
    localparam int WW = $clog2(TIMEOUT_CYC + 1);
    typedef enum logic [1:0] {IDLE, GRANT, XFER, GAP} state_t;
    state_t                 state, state_nx;
    logic [SW-1:0]          ptr, ptr_nx, win, idx, sel_nx;
    logic [WW-1:0]          wdog, wdog_nx;
    logic                   sel_vld_nx, done_nx, to_nx;
    logic [IN_PORT_NUM-1:0] rd_req_nx;
    logic [CNT_W-1:0]       cnt_nx;
    // round-robin search past ptr; offsets scanned high to low so the nearest set bit wins
    always_comb begin
        win = ptr;
        idx = ptr;
        for (int i = IN_PORT_NUM; i >= 1; i--) begin
            idx = ptr + SW'(i);
            if (i_req[idx]) win = idx;
        end
    end
    // next state and next values of every registered output
    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        wdog_nx    = wdog;
        sel_nx     = o_sel;
        sel_vld_nx = 1'b0;
        rd_req_nx  = '0;
        done_nx    = 1'b0;
        to_nx      = 1'b0;
        cnt_nx     = o_pkt_cnt;
        if (!i_en) begin
            state_nx = IDLE;
            wdog_nx  = '0;
            sel_nx   = '0;
        end else begin
            case (state)
                IDLE: if (|i_req) begin
                    state_nx   = GRANT;
                    ptr_nx     = win;
                    sel_nx     = win;
                    sel_vld_nx = 1'b1;
                    rd_req_nx  = IN_PORT_NUM'(1) << win;
                end
                GRANT: begin
                    state_nx = XFER;
                    wdog_nx  = '0;
                end
                XFER: if (i_rd_vld && i_rd_eop) begin
                    state_nx = GAP;
                    done_nx  = 1'b1;
                    cnt_nx   = o_pkt_cnt + CNT_W'(1);
                end else if (i_rd_vld) begin
                    wdog_nx = '0;
                end else if (wdog == WW'(TIMEOUT_CYC - 1)) begin
                    state_nx = IDLE;
                    to_nx    = 1'b1;
                end else begin
                    wdog_nx = wdog + WW'(1);
                end
                GAP: state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end
    // state, pointer, watchdog and output registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            ptr        <= '1;
            wdog       <= '0;
            o_sel      <= '0;
            o_sel_vld  <= 1'b0;
            o_rd_req   <= '0;
            o_busy     <= 1'b0;
            o_pkt_done <= 1'b0;
            o_timeout  <= 1'b0;
            o_pkt_cnt  <= '0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            wdog       <= wdog_nx;
            o_sel      <= sel_nx;
            o_sel_vld  <= sel_vld_nx;
            o_rd_req   <= rd_req_nx;
            o_busy     <= state_nx != IDLE;
            o_pkt_done <= done_nx;
            o_timeout  <= to_nx;
            o_pkt_cnt  <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_out_port_sched.sv
// tb_out_port_sched: scoreboard bench for the output-port round-robin scheduler
module tb_out_port_sched;
    localparam int N  = 16;
    localparam int TO = 1024;
    localparam int CW = 8;
    localparam int G  = 0;
    localparam int D  = 1;
    localparam int T  = 2;
    typedef struct {
        int kind;
        int sel;
        int cnt;
        int cyc;
    } ev_t;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          vld = 1'b0;
    logic          eop = 1'b0;
    logic [N-1:0]  req = '0;
    logic [3:0]    sel;
    logic          sel_vld;
    logic [N-1:0]  rd_req;
    logic          busy;
    logic          done;
    logic          tout;
    logic [CW-1:0] cnt;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_cnt = 0;
    int g = 0;
    int order[5] = '{0, 5, 10, 15, 0};
    ev_t q[$];

    out_port_sched #(.IN_PORT_NUM(N), .TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_en(en),
        .i_req(req),
        .i_rd_vld(vld),
        .i_rd_eop(eop),
        .o_sel(sel),
        .o_sel_vld(sel_vld),
        .o_rd_req(rd_req),
        .o_busy(busy),
        .o_pkt_done(done),
        .o_timeout(tout),
        .o_pkt_cnt(cnt)
    );

    // free-running clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int s, input int c, input int cy);
        q.push_back('{k, s, c, cy});
    endtask

    function automatic string kname(input int k);
        return k == G ? "grant" : (k == D ? "done" : "timeout");
    endfunction

    task automatic expect_ev(input int k);
        ev_t e;
        logic [N-1:0] one;
        bit bad;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: at cycle %0d sel %0d cnt %0d, no event expected", kname(k), cyc, sel, cnt);
            return;
        end
        e = q.pop_front();
        one = N'(1) << e.sel;
        bad = e.kind != k || e.cyc != cyc;
        if (k == G) bad = bad || int'(sel) != e.sel || rd_req != one;
        else bad = bad || int'(cnt) != e.cnt;
        if (bad) begin
            errors++;
            $display("FAIL %s_event: got %s cycle %0d sel %0d rd_req %h cnt %0d, expected %s cycle %0d sel %0d cnt %0d",
                     kname(k), kname(k), cyc, sel, rd_req, cnt, kname(e.kind), e.cyc, e.sel, e.cnt);
        end
    endtask

    task automatic mon_loop;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sel_vld) expect_ev(G);
                else chk("rd_req_idle", int'(rd_req), 0);
                if (done) expect_ev(D);
                if (tout) expect_ev(T);
            end
        end
    endtask

    task automatic pkt(input logic [N-1:0] r, input int port, input int beats, input bit hold);
        req = r;
        push(G, port, 0, cyc + 1);
        tick;
        if (!hold) req = '0;
        tick;
        for (int b = 0; b < beats; b++) begin
            vld = 1'b1;
            eop = b == beats - 1;
            if (b == beats - 1) begin
                exp_cnt = (exp_cnt + 1) % (1 << CW);
                push(D, 0, exp_cnt, cyc + 1);
            end
            tick;
        end
        vld = 1'b0;
        eop = 1'b0;
        tick;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        exp_cnt = 0;
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        fork
            mon_loop();
        join_none
        en = 1'b1;
        repeat (3) tick;
        chk("rst_sel", sel, 0);
        chk("rst_sel_vld", sel_vld, 0);
        chk("rst_rd_req", int'(rd_req), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", tout, 0);
        chk("rst_cnt", cnt, 0);
        rst_n = 1'b1;
        tick;
        pkt(16'h0001, 0, 4, 1'b0);
        chk("cnt_first_pkt", cnt, 1);
        do_reset;
        for (int k = 0; k < 5; k++) pkt(16'h8421, order[k], 1, k < 4);
        req = 16'h0008;
        push(G, 3, 0, cyc + 1);
        tick;
        g = cyc;
        req = '0;
        eop = 1'b1;
        push(T, 0, exp_cnt, g + TO + 1);
        while (cyc < g + TO + 1) tick;
        eop = 1'b0;
        chk("busy_after_timeout", busy, 0);
        chk("cnt_after_timeout", cnt, exp_cnt);
        pkt(16'h0018, 4, 2, 1'b0);
        req = 16'h0020;
        push(G, 5, 0, cyc + 1);
        tick;
        g = cyc;
        req = '0;
        while (cyc < g + TO) tick;
        vld = 1'b1;
        eop = 1'b1;
        exp_cnt = exp_cnt + 1;
        push(D, 0, exp_cnt, cyc + 1);
        tick;
        vld = 1'b0;
        eop = 1'b0;
        tick;
        req = 16'h0080;
        push(G, 7, 0, cyc + 1);
        tick;
        req = '0;
        tick;
        chk("busy_xfer7", busy, 1);
        chk("sel_xfer7", sel, 7);
        en = 1'b0;
        vld = 1'b1;
        eop = 1'b1;
        tick;
        vld = 1'b0;
        eop = 1'b0;
        chk("busy_disabled", busy, 0);
        chk("sel_disabled", sel, 0);
        chk("cnt_disabled", cnt, exp_cnt);
        req = 16'h0081;
        repeat (3) tick;
        en = 1'b1;
        pkt(16'h0081, 0, 1, 1'b0);
        do_reset;
        for (int k = 0; k < 256; k++) pkt(16'h0001, 0, 1, k < 255);
        chk("cnt_wrapped", cnt, 0);
        pkt(16'h0002, 1, 1, 1'b0);
        req = 16'h0004;
        push(G, 2, 0, cyc + 1);
        tick;
        req = '0;
        tick;
        vld = 1'b1;
        tick;
        chk("busy_before_areset", busy, 1);
        chk("sel_before_areset", sel, 2);
        chk("cnt_before_areset", cnt, 1);
        rst_n = 1'b0;
        #1;
        chk("areset_busy", busy, 0);
        chk("areset_sel", sel, 0);
        chk("areset_cnt", cnt, 0);
        chk("areset_rd_req", int'(rd_req), 0);
        chk("areset_pulses", {sel_vld, done, tout}, 0);
        vld = 1'b0;
        tick;
        rst_n = 1'b1;
        repeat (3) tick;
        chk("events_outstanding", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_port_sched.md
Name: out_port_sched

Overview:
- Packet-level round-robin scheduler for one output port of the multi-port cache.
- Chooses which of IN_PORT_NUM input ports may send its next packet.
- Drives the 16:1 read-data mux select (o_sel/o_sel_vld) and the per-port read request.
- Holds the grant from packet start until the mux output shows eop, or until a watchdog timeout fires.

Parameters:
- IN_PORT_NUM, 16: number of requesting input ports; power of two, at least 2.
- TIMEOUT_CYC, 1024: maximum number of consecutive XFER cycles without o-side valid before the packet is aborted.
- CNT_W, 16: width of the completed-packet counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  enable; when low the block is held idle, same as reset except the RR pointer and counter are kept.
- i_req  in  IN_PORT_NUM  per-port "packet pending for this output" level.
- i_rd_vld  in  1  mux output valid.
- i_rd_eop  in  1  mux output end-of-packet.
- o_sel  out  $clog2(IN_PORT_NUM)  selected port index to the mux.
- o_sel_vld  out  1  one-cycle pulse; mux latches o_sel on it.
- o_rd_req  out  IN_PORT_NUM  one-hot, one-cycle read-start pulse to the granted port.
- o_busy  out  1  high in GRANT, XFER and GAP.
- o_pkt_done  out  1  one-cycle pulse on normal packet completion.
- o_timeout  out  1  one-cycle pulse on watchdog abort.
- o_pkt_cnt  out  CNT_W  count of completed packets; wraps modulo 2^CNT_W; timeouts are not counted.

Behaviour:
- Reset (async, i_rst_n low): state IDLE, all outputs 0, RR pointer ptr = IN_PORT_NUM-1 (so port 0 has first priority), watchdog 0.
- All outputs are registered.
- States: IDLE, GRANT, XFER, GAP.
- IDLE:
  - If i_en and any i_req bit is set, pick the first set bit searching ptr+1, ptr+2, … modulo IN_PORT_NUM.
  - Next cycle: state GRANT, o_sel = winner, o_sel_vld = 1, o_rd_req = one-hot(winner), ptr = winner.
  - Otherwise stay in IDLE.
- GRANT: lasts exactly 1 cycle. o_sel_vld and o_rd_req are high only here. Next state XFER, watchdog cleared.
  - Request-to-grant latency: 1 clock from the first i_req edge observed in IDLE.
- XFER:
  - o_sel holds the winner.
  - i_rd_vld & i_rd_eop → next state GAP, o_pkt_done = 1, o_pkt_cnt += 1.
  - Otherwise, any i_rd_vld clears the watchdog; no valid increments it.
  - Watchdog reaching TIMEOUT_CYC-1 with no valid → next state IDLE, o_timeout = 1. The pointer stays on the aborted port, so it has lowest priority next.
  - i_req changes during XFER are ignored; a new eop after completion is ignored.
  - eop without vld is ignored.
- GAP: 1 idle cycle, then IDLE. Back-to-back packets are therefore separated by at least 2 cycles between eop and the next o_sel_vld.
- Simultaneous watchdog expiry and vld & eop in the same cycle: completion wins; no timeout pulse.
- i_en low in any state:
  - Next cycle the block is in IDLE with o_sel, o_sel_vld, o_rd_req, o_busy and pulses at 0.
  - ptr and o_pkt_cnt are held.
  - A packet in flight is abandoned silently (no done, no timeout).
  - The mux independently resets its select when disabled.
- Async reset asserted mid-packet: immediate return to reset values; no pulse is generated.
- A single requester is re-granted after each GAP if its i_req stays high.

Test Plan:
- Reset release, i_req = 16'h0001, then one 4-beat packet with eop on beat 4:
  - o_sel_vld and o_rd_req = 16'h0001 exactly 1 cycle after the req is seen, o_sel = 0.
  - o_pkt_done pulses on the eop cycle + 1; o_pkt_cnt = 1.
- i_req = 16'h8421 held high, 1-beat packets:
  - Grant order is 0, 5, 10, 15, 0; each grant is 4 cycles after the previous (GRANT, XFER, GAP, IDLE).
  - ptr wraps 15 → 0.
- Granted port 3 and no i_rd_vld for 1024 cycles:
  - o_timeout pulses once; o_pkt_cnt is unchanged.
  - With i_req = 16'h0018 the next grant is port 4, not 3.
- Watchdog at 1023 in the same cycle as vld & eop: o_pkt_done = 1, o_timeout = 0.
- i_en dropped in XFER at port 7:
  - Next cycle o_busy = 0, o_sel = 0, no pulses.
  - After i_en returns with i_req = 16'h0081, the grant is port 0 (ptr held at 7).
- o_pkt_cnt preloaded by 65535 completions, then one more packet: o_pkt_cnt = 0. Async reset mid-XFER: all outputs 0 within the same cycle.
